fpu_dispatch: RTL and testbench

Buffers floating-point commands from register read, issues them to the dFPU through its `f_in_vld`/`f_in_rdy` handshake, and collects results through `f_out_vld`/`f_out_rdy`. Each result is paired with its destination register tag and presented to FP register-file writeback. The block sits directly between the register-read stage and the dFPU and wraps both of the dFPU's handshakes. The dFPU completes operations in order, so tag matching is FIFO order.

---
 rtl/fpu_dispatch.sv | 184 ++++++++++++++++++
 tb/tb_fpu_dispatch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_dispatch.sv
// fpu_dispatch: command FIFO and issue slot in front of the dFPU, an in-order
// tag FIFO matching returned results to destination registers, and a writeback register.
module fpu_dispatch #(
  parameter int DEPTH = 4,
  parameter int TAGS  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [3:0]  cmd_ope,
  input  logic [31:0] cmd_src1,
  input  logic [31:0] cmd_src2,
  input  logic [5:0]  cmd_rd,
  output logic [3:0]  f_ope_data,
  output logic [31:0] f_in1_data,
  output logic [31:0] f_in2_data,
  output logic        f_in_vld,
  input  logic        f_in_rdy,
  input  logic [31:0] f_out_data,
  input  logic [2:0]  f_err,
  input  logic        f_out_vld,
  output logic        f_out_rdy,
  output logic        wb_vld,
  input  logic        wb_rdy,
  output logic [5:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_err,
  output logic [3:0]  err_sticky,
  output logic        busy
);
  localparam int CPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CCW = $clog2(DEPTH + 1);
  localparam int TPW = (TAGS > 1) ? $clog2(TAGS) : 1;
  localparam int TCW = $clog2(TAGS + 1);
  localparam logic [CPW-1:0] CPTR_LAST = CPW'(DEPTH - 1);
  localparam logic [CCW-1:0] CCNT_FULL = CCW'(DEPTH);
  localparam logic [TPW-1:0] TPTR_LAST = TPW'(TAGS - 1);
  localparam logic [TCW-1:0] TAGS_MAX  = TCW'(TAGS);

  typedef struct packed {
    logic [3:0]  ope;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [5:0]  rd;
  } cmd_t;

  cmd_t           cmd_mem_r [DEPTH];
  cmd_t           cmd_in_s;
  logic [CPW-1:0] cmd_wptr_r, cmd_rptr_r;
  logic [CCW-1:0] cmd_count_r, cmd_count_s;
  logic           cmd_rdy_r;
  logic           run_r;
  cmd_t           slot_r;
  logic           slot_vld_r;
  logic [5:0]     tag_mem_r [TAGS];
  logic [TPW-1:0] tag_wptr_r, tag_rptr_r;
  logic [TCW-1:0] tag_count_r, tag_count_s;
  logic [TCW-1:0] outstanding_r, outstanding_s;
  logic           wb_vld_r;
  logic [5:0]     wb_rd_r;
  logic [31:0]    wb_data_r;
  logic [2:0]     wb_err_r;
  logic [3:0]     err_sticky_r;
  logic           push_s, accept_s, load_s, f_out_rdy_s;
  logic           res_fire_s, res_ok_s, res_bad_s;

  function automatic logic [CPW-1:0] cmd_ptr_inc(input logic [CPW-1:0] p);
    return (p == CPTR_LAST) ? '0 : p + CPW'(1);
  endfunction

  function automatic logic [TPW-1:0] tag_ptr_inc(input logic [TPW-1:0] p);
    return (p == TPTR_LAST) ? '0 : p + TPW'(1);
  endfunction

  assign cmd_in_s    = '{ope: cmd_ope, src1: cmd_src1, src2: cmd_src2, rd: cmd_rd};
  assign push_s      = cmd_vld & cmd_rdy_r;
  assign accept_s    = slot_vld_r & f_in_rdy;
  // The accepted slot moves into the tag FIFO, so it still counts as outstanding.
  assign load_s      = (cmd_count_r != '0) & (~slot_vld_r | accept_s) & (outstanding_r < TAGS_MAX);
  assign f_out_rdy_s = run_r & (~wb_vld_r | wb_rdy);
  assign res_fire_s  = f_out_vld & f_out_rdy_s;
  assign res_ok_s    = res_fire_s & (tag_count_r != '0);
  assign res_bad_s   = res_fire_s & (tag_count_r == '0);

  // Next-state occupancy counters for the command FIFO, tag FIFO and in-flight total.
  always_comb begin
    cmd_count_s   = cmd_count_r;
    tag_count_s   = tag_count_r;
    outstanding_s = outstanding_r;
    case ({push_s, load_s})
      2'b10:   cmd_count_s = cmd_count_r + CCW'(1);
      2'b01:   cmd_count_s = cmd_count_r - CCW'(1);
      default: cmd_count_s = cmd_count_r;
    endcase
    case ({accept_s, res_ok_s})
      2'b10:   tag_count_s = tag_count_r + TCW'(1);
      2'b01:   tag_count_s = tag_count_r - TCW'(1);
      default: tag_count_s = tag_count_r;
    endcase
    case ({load_s, res_ok_s})
      2'b10:   outstanding_s = outstanding_r + TCW'(1);
      2'b01:   outstanding_s = outstanding_r - TCW'(1);
      default: outstanding_s = outstanding_r;
    endcase
  end

  // FIFO storage arrays; contents are don't-care until their pointers make them visible.
  always_ff @(posedge clk) begin
    if (push_s) begin
      cmd_mem_r[cmd_wptr_r] <= cmd_in_s;
    end
    if (accept_s) begin
      tag_mem_r[tag_wptr_r] <= slot_r.rd;
    end
  end

  // Control state, issue slot and writeback register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_r         <= 1'b0;
      cmd_rdy_r     <= 1'b0;
      cmd_wptr_r    <= '0;
      cmd_rptr_r    <= '0;
      cmd_count_r   <= '0;
      slot_r        <= '0;
      slot_vld_r    <= 1'b0;
      tag_wptr_r    <= '0;
      tag_rptr_r    <= '0;
      tag_count_r   <= '0;
      outstanding_r <= '0;
      wb_vld_r      <= 1'b0;
      wb_rd_r       <= 6'd0;
      wb_data_r     <= 32'd0;
      wb_err_r      <= 3'd0;
      err_sticky_r  <= 4'd0;
    end else begin
      run_r         <= 1'b1;
      cmd_rdy_r     <= (cmd_count_s != CCNT_FULL);
      cmd_count_r   <= cmd_count_s;
      tag_count_r   <= tag_count_s;
      outstanding_r <= outstanding_s;
      if (push_s) begin
        cmd_wptr_r <= cmd_ptr_inc(cmd_wptr_r);
      end
      if (load_s) begin
        cmd_rptr_r <= cmd_ptr_inc(cmd_rptr_r);
        slot_r     <= cmd_mem_r[cmd_rptr_r];
        slot_vld_r <= 1'b1;
      end else if (accept_s) begin
        slot_vld_r <= 1'b0;
      end
      if (accept_s) begin
        tag_wptr_r <= tag_ptr_inc(tag_wptr_r);
      end
      if (res_ok_s) begin
        tag_rptr_r   <= tag_ptr_inc(tag_rptr_r);
        wb_vld_r     <= 1'b1;
        wb_rd_r      <= tag_mem_r[tag_rptr_r];
        wb_data_r    <= f_out_data;
        wb_err_r     <= f_err;
        err_sticky_r <= err_sticky_r | {1'b0, f_err};
      end else if (wb_vld_r & wb_rdy) begin
        wb_vld_r <= 1'b0;
      end
      if (res_bad_s) begin
        err_sticky_r[3] <= 1'b1;
      end
    end
  end

  assign cmd_rdy    = cmd_rdy_r;
  assign f_ope_data = slot_r.ope;
  assign f_in1_data = slot_r.src1;
  assign f_in2_data = slot_r.src2;
  assign f_in_vld   = slot_vld_r;
  assign f_out_rdy  = f_out_rdy_s;
  assign wb_vld     = wb_vld_r;
  assign wb_rd      = wb_rd_r;
  assign wb_data    = wb_data_r;
  assign wb_err     = wb_err_r;
  assign err_sticky = err_sticky_r;
  assign busy       = (cmd_count_r != '0) | slot_vld_r | (tag_count_r != '0) | wb_vld_r;
endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed self-checking bench for fpu_dispatch: reset, single op, FIFO full,
// writeback stall ordering, unexpected results / error flags, and the in-flight tag limit.
module tb_fpu_dispatch;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [3:0]  cmd_ope = 4'd0;
  logic [31:0] cmd_src1 = 32'd0;
  logic [31:0] cmd_src2 = 32'd0;
  logic [5:0]  cmd_rd = 6'd0;
  logic [3:0]  f_ope_data;
  logic [31:0] f_in1_data, f_in2_data;
  logic        f_in_vld;
  logic        f_in_rdy = 1'b0;
  logic [31:0] f_out_data = 32'd0;
  logic [2:0]  f_err = 3'd0;
  logic        f_out_vld = 1'b0;
  logic        f_out_rdy;
  logic        wb_vld;
  logic        wb_rdy = 1'b0;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  wb_err;
  logic [3:0]  err_sticky;
  logic        busy;
  int total = 0;
  int bad = 0;

  fpu_dispatch #(.DEPTH(4), .TAGS(4)) dut (
    .clk(clk), .rstn(rstn), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_ope(cmd_ope),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_rd(cmd_rd), .f_ope_data(f_ope_data),
    .f_in1_data(f_in1_data), .f_in2_data(f_in2_data), .f_in_vld(f_in_vld), .f_in_rdy(f_in_rdy),
    .f_out_data(f_out_data), .f_err(f_err), .f_out_vld(f_out_vld), .f_out_rdy(f_out_rdy),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err),
    .err_sticky(err_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  // One active edge, then settle on the falling edge where outputs are sampled and inputs driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cmd_vld = 1'b0; f_in_rdy = 1'b0; f_out_vld = 1'b0; wb_rdy = 1'b0;
    f_out_data = 32'd0; f_err = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    step();
  endtask

  task automatic send_cmd(input logic [3:0] ope, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [5:0] rd);
    cmd_vld = 1'b1; cmd_ope = ope; cmd_src1 = s1; cmd_src2 = s2; cmd_rd = rd;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rstn = 1'b0;
    send_cmd(4'hA, 32'h1234_5678, 32'h9ABC_DEF0, 6'd3);
    step();
    total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_cmd_rdy got=%0b exp=0", cmd_rdy); end
    total++; if (f_in_vld !== 1'b0) begin bad++; $display("FAIL reset_f_in_vld got=%0b exp=0", f_in_vld); end
    total++; if (f_out_rdy !== 1'b0) begin bad++; $display("FAIL reset_f_out_rdy got=%0b exp=0", f_out_rdy); end
    total++; if (wb_vld !== 1'b0) begin bad++; $display("FAIL reset_wb_vld got=%0b exp=0", wb_vld); end
    total++; if (err_sticky !== 4'd0) begin bad++; $display("FAIL reset_err_sticky got=%0h exp=0", err_sticky); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if ({f_ope_data, f_in1_data, f_in2_data} !== 68'd0) begin bad++; $display("FAIL reset_slot_data got=%0h exp=0", {f_ope_data, f_in1_data, f_in2_data}); end
    total++; if ({wb_rd, wb_data, wb_err} !== 41'd0) begin bad++; $display("FAIL reset_wb_data got=%0h exp=0", {wb_rd, wb_data, wb_err}); end
    step();
    rstn = 1'b1;
    step();
    cmd_vld = 1'b0;
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL release_cmd_rdy got=%0b exp=1", cmd_rdy); end
    total++; if (f_out_rdy !== 1'b1) begin bad++; $display("FAIL release_f_out_rdy got=%0b exp=1", f_out_rdy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_no_push got=%0b exp=0", busy); end
    step();
    total++; if (f_in_vld !== 1'b0) begin bad++; $display("FAIL release_no_issue got=%0b exp=0", f_in_vld); end
  endtask

  task automatic test_single_op();
    do_reset();
    send_cmd(4'h1, 32'h3F80_0000, 32'h4000_0000, 6'd5);
    step();
    cmd_vld = 1'b0;
    total++; if (f_in_vld !== 1'b0) begin bad++; $display("FAIL single_vld_e0 got=%0b exp=0", f_in_vld); end
    step();
    total++; if (f_in_vld !== 1'b1) begin bad++; $display("FAIL single_vld_e1 got=%0b exp=1", f_in_vld); end
    total++; if ({f_ope_data, f_in1_data, f_in2_data} !== {4'h1, 32'h3F80_0000, 32'h4000_0000}) begin
      bad++; $display("FAIL single_issue_data got=%0h exp=%0h", {f_ope_data, f_in1_data, f_in2_data}, {4'h1, 32'h3F80_0000, 32'h4000_0000}); end
    f_in_rdy = 1'b1;
    step();
    f_in_rdy = 1'b0;
    total++; if (f_in_vld !== 1'b0) begin bad++; $display("FAIL single_vld_after_accept got=%0b exp=0", f_in_vld); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_inflight got=%0b exp=1", busy); end
    f_out_vld = 1'b1; f_out_data = 32'h4040_0000; f_err = 3'd0;
    step();
    f_out_vld = 1'b0;
    total++; if (wb_vld !== 1'b1) begin bad++; $display("FAIL single_wb_vld got=%0b exp=1", wb_vld); end
    total++; if (wb_rd !== 6'd5) begin bad++; $display("FAIL single_wb_rd got=%0d exp=5", wb_rd); end
    total++; if (wb_data !== 32'h4040_0000) begin bad++; $display("FAIL single_wb_data got=%0h exp=40400000", wb_data); end
    total++; if (wb_err !== 3'd0) begin bad++; $display("FAIL single_wb_err got=%0b exp=0", wb_err); end
    wb_rdy = 1'b1;
    step();
    wb_rdy = 1'b0;
    total++; if (wb_vld !== 1'b0) begin bad++; $display("FAIL single_wb_clear got=%0b exp=0", wb_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_cmd(4'(i + 1), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 6'(10 + i));
      step();
      total++; if (cmd_rdy !== (i < 4)) begin bad++; $display("FAIL full_cmd_rdy_%0d got=%0b exp=%0b", i, cmd_rdy, (i < 4)); end
    end
    cmd_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if ({f_in_vld, f_ope_data, f_in1_data, f_in2_data} !== {1'b1, 4'h1, 32'h1000, 32'h2000}) begin
        bad++; $display("FAIL full_slot_stable_%0d got=%0h exp=%0h", k, {f_in_vld, f_ope_data, f_in1_data, f_in2_data}, {1'b1, 4'h1, 32'h1000, 32'h2000}); end
      total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL full_cmd_rdy_hold_%0d got=%0b exp=0", k, cmd_rdy); end
    end
    f_in_rdy = 1'b1;
    step();
    f_in_rdy = 1'b0;
    total++; if ({f_in_vld, f_ope_data, f_in1_data} !== {1'b1, 4'h2, 32'h1001}) begin
      bad++; $display("FAIL full_next_slot got=%0h exp=%0h", {f_in_vld, f_ope_data, f_in1_data}, {1'b1, 4'h2, 32'h1001}); end
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL full_cmd_rdy_after_pop got=%0b exp=1", cmd_rdy); end
  endtask

  task automatic test_wb_stall();
    do_reset();
    f_in_rdy = 1'b1;
    send_cmd(4'h2, 32'h1, 32'h2, 6'd5);
    step();
    send_cmd(4'h3, 32'h3, 32'h4, 6'd6);
    step();
    cmd_vld = 1'b0;
    step(); step(); step();
    f_in_rdy = 1'b0;
    total++; if (f_out_rdy !== 1'b1) begin bad++; $display("FAIL stall_rdy_initial got=%0b exp=1", f_out_rdy); end
    f_out_vld = 1'b1; f_out_data = 32'hAAAA_0001;
    step();
    f_out_data = 32'hBBBB_0002;
    total++; if (f_out_rdy !== 1'b0) begin bad++; $display("FAIL stall_rdy_low got=%0b exp=0", f_out_rdy); end
    total++; if ({wb_vld, wb_rd, wb_data} !== {1'b1, 6'd5, 32'hAAAA_0001}) begin
      bad++; $display("FAIL stall_first got=%0h exp=%0h", {wb_vld, wb_rd, wb_data}, {1'b1, 6'd5, 32'hAAAA_0001}); end
    step();
    total++; if ({wb_vld, wb_rd, wb_data} !== {1'b1, 6'd5, 32'hAAAA_0001}) begin
      bad++; $display("FAIL stall_hold got=%0h exp=%0h", {wb_vld, wb_rd, wb_data}, {1'b1, 6'd5, 32'hAAAA_0001}); end
    wb_rdy = 1'b1;
    step();
    f_out_vld = 1'b0;
    total++; if ({wb_vld, wb_rd, wb_data} !== {1'b1, 6'd6, 32'hBBBB_0002}) begin
      bad++; $display("FAIL stall_second got=%0h exp=%0h", {wb_vld, wb_rd, wb_data}, {1'b1, 6'd6, 32'hBBBB_0002}); end
    step();
    wb_rdy = 1'b0;
    total++; if (wb_vld !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0b exp=0", wb_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_unexpected();
    do_reset();
    f_out_vld = 1'b1; f_out_data = 32'hDEAD_BEEF; f_err = 3'b100;
    step();
    f_out_vld = 1'b0; f_err = 3'd0;
    total++; if (err_sticky !== 4'b1000) begin bad++; $display("FAIL unexp_sticky got=%0b exp=1000", err_sticky); end
    total++; if (wb_vld !== 1'b0) begin bad++; $display("FAIL unexp_no_wb got=%0b exp=0", wb_vld); end
    send_cmd(4'h4, 32'h5, 32'h6, 6'd7);
    f_in_rdy = 1'b1;
    step();
    cmd_vld = 1'b0;
    step(); step();
    f_in_rdy = 1'b0;
    f_out_vld = 1'b1; f_out_data = 32'h0000_0077; f_err = 3'b010;
    step();
    f_out_vld = 1'b0; f_err = 3'd0;
    total++; if ({wb_vld, wb_rd, wb_err} !== {1'b1, 6'd7, 3'b010}) begin
      bad++; $display("FAIL err_wb got=%0h exp=%0h", {wb_vld, wb_rd, wb_err}, {1'b1, 6'd7, 3'b010}); end
    total++; if (err_sticky !== 4'b1010) begin bad++; $display("FAIL err_sticky_or got=%0b exp=1010", err_sticky); end
    wb_rdy = 1'b1;
    step();
    wb_rdy = 1'b0;
    total++; if (err_sticky !== 4'b1010) begin bad++; $display("FAIL err_sticky_hold got=%0b exp=1010", err_sticky); end
  endtask

  task automatic test_tag_limit();
    int accepts = 0;
    do_reset();
    f_in_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_cmd(4'(i + 1), 32'h3000 + 32'(i), 32'h4000 + 32'(i), 6'(20 + i));
      step();
      if (f_in_vld === 1'b1) accepts++;
    end
    cmd_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (f_in_vld === 1'b1) accepts++;
    end
    total++; if (accepts != 4) begin bad++; $display("FAIL tags_accepts got=%0d exp=4", accepts); end
    total++; if (f_in_vld !== 1'b0) begin bad++; $display("FAIL tags_vld_low got=%0b exp=0", f_in_vld); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tags_busy got=%0b exp=1", busy); end
    total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL tags_cmd_rdy got=%0b exp=1", cmd_rdy); end
    f_out_vld = 1'b1; f_out_data = 32'hCAFE_0000; wb_rdy = 1'b1;
    step();
    f_out_vld = 1'b0;
    total++; if ({wb_vld, wb_rd} !== {1'b1, 6'd20}) begin bad++; $display("FAIL tags_first_wb got=%0h exp=%0h", {wb_vld, wb_rd}, {1'b1, 6'd20}); end
    total++; if (f_in_vld !== 1'b0) begin bad++; $display("FAIL tags_no_issue_yet got=%0b exp=0", f_in_vld); end
    step();
    total++; if ({f_in_vld, f_ope_data, f_in1_data} !== {1'b1, 4'h5, 32'h3004}) begin
      bad++; $display("FAIL tags_resume got=%0h exp=%0h", {f_in_vld, f_ope_data, f_in1_data}, {1'b1, 4'h5, 32'h3004}); end
    total++; if (wb_vld !== 1'b0) begin bad++; $display("FAIL tags_wb_clear got=%0b exp=0", wb_vld); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fifo_full();
    test_wb_stall();
    test_unexpected();
    test_tag_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
